button_bank: RTL and testbench

- Parametrised multi-channel push-button conditioner for the game's input panel (paddle left/right, launch, pause).
- Each channel has a 2-flop synchroniser, a debounce counter, a one-clock press pulse and an optional typematic auto-repeat for held buttons.
- It also provides a debounced level output.
- Sits between the board pins and the game control FSM; one instance serves all buttons.

---
 rtl/button_bank.sv | 157 +++++++++++++++
 tb/tb_button_bank.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// Multi-channel push-button conditioner: per-channel synchroniser, debounce,
// one-clock press pulse, optional typematic auto-repeat and debounced level.
module button_bank #(
    parameter int N_BUTTONS       = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_RATE     = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] entrada,
    input  logic [N_BUTTONS-1:0] repeat_en,
    output logic [N_BUTTONS-1:0] saida,
    output logic [N_BUTTONS-1:0] nivel
);

    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] DB_LOAD   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LOAD   = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RR_LOAD   = CW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HELD       = 3'd2,
        ST_REPEAT     = 3'd3,
        ST_RELEASE_DB = 3'd4
    } state_t;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
        logic          sync1_r;
        logic          sync2_r;
        logic          act_s;
        state_t        state_r;
        state_t        state_s;
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_s;
        logic          pulse_r;
        logic          pulse_s;
        logic          level_r;
        logic          level_s;

        // Two-flop synchroniser; reset parks it at the idle pin level.
        always_ff @(posedge clock) begin
            if (reset) begin
                sync1_r <= ACTIVE_LOW;
                sync2_r <= ACTIVE_LOW;
            end else begin
                sync1_r <= entrada[g];
                sync2_r <= sync1_r;
            end
        end

        assign act_s = sync2_r ^ ACTIVE_LOW;

        // Next-state, counter and output decode for one channel.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            pulse_s = 1'b0;
            level_s = level_r;
            case (state_r)
                ST_IDLE: begin
                    if (act_s) begin
                        cnt_s   = DB_LOAD;
                        state_s = ST_PRESS_DB;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_PRESS_DB: begin
                    if (!act_s) begin
                        state_s = ST_IDLE;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_s = ST_HELD;
                        pulse_s = 1'b1;
                        level_s = 1'b1;
                        cnt_s   = RD_LOAD;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!act_s) begin
                        state_s = ST_RELEASE_DB;
                        cnt_s   = DB_LOAD;
                    end else if ((cnt_r == CNT_ZERO) && repeat_en[g]) begin
                        state_s = ST_REPEAT;
                        pulse_s = 1'b1;
                        cnt_s   = RR_LOAD;
                    end else if (cnt_r != CNT_ZERO) begin
                        cnt_s = cnt_r - CNT_ONE;
                    end else begin
                        // Delay expired but repeat disabled: wait here at zero.
                        cnt_s = CNT_ZERO;
                    end
                end
                ST_REPEAT: begin
                    if (!act_s) begin
                        state_s = ST_RELEASE_DB;
                        cnt_s   = DB_LOAD;
                    end else if (!repeat_en[g]) begin
                        state_s = ST_HELD;
                        cnt_s   = RD_LOAD;
                    end else if (cnt_r == CNT_ZERO) begin
                        pulse_s = 1'b1;
                        cnt_s   = RR_LOAD;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                ST_RELEASE_DB: begin
                    // A bounce back to pressed resumes holding without a new press pulse.
                    if (act_s) begin
                        state_s = ST_HELD;
                        cnt_s   = RD_LOAD;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_s = ST_IDLE;
                        level_s = 1'b0;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                    level_s = 1'b0;
                end
            endcase
        end

        // State, counter and registered outputs.
        always_ff @(posedge clock) begin
            if (reset) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
                pulse_r <= 1'b0;
                level_r <= 1'b0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
                pulse_r <= pulse_s;
                level_r <= level_s;
            end
        end

        assign saida[g] = pulse_r;
        assign nivel[g] = level_r;
    end

endmodule

// File: tb/tb_button_bank.sv
// Randomised + directed bench for button_bank; an event-timing reference model
// feeds an expectation queue drained by an independent output monitor.
module tb_button_bank;
    localparam int N  = 4;
    localparam bit AL = 1'b1;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] entrada;
    logic [N-1:0] repeat_en;
    logic [N-1:0] saida;
    logic [N-1:0] nivel;

    button_bank #(
        .N_BUTTONS(N), .ACTIVE_LOW(AL), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clock(clock), .reset(reset), .entrada(entrada),
        .repeat_en(repeat_en), .saida(saida), .nivel(nivel)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [N-1:0] p;
        logic [N-1:0] l;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: run lengths of the pressed/released level and time elapsed
    // since the last pulse or delay restart.
    bit m_s1[N], m_s2[N], m_lvl[N], m_rep[N];
    int m_ones[N], m_zeros[N], m_el[N];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [N-1:0] pin, input logic [N-1:0] en);
        exp_t e;
        for (int c = 0; c < N; c++) begin
            bit act;
            bit pulse;
            pulse = 1'b0;
            if (rst) begin
                m_s1[c] = AL; m_s2[c] = AL; m_lvl[c] = 1'b0; m_rep[c] = 1'b0;
                m_ones[c] = 0; m_zeros[c] = 0; m_el[c] = 0;
            end else begin
                act = m_s2[c] ^ AL;
                m_s2[c] = m_s1[c];
                m_s1[c] = pin[c];
                if (!m_lvl[c]) begin
                    if (act) begin
                        m_ones[c]++;
                        if (m_ones[c] == D + 1) begin
                            pulse = 1'b1; m_lvl[c] = 1'b1; m_el[c] = 0;
                            m_rep[c] = 1'b0; m_zeros[c] = 0;
                        end
                    end else begin
                        m_ones[c] = 0;
                    end
                end else if (m_zeros[c] > 0 || !act) begin
                    if (!act) begin
                        m_zeros[c]++;
                        if (m_zeros[c] == D + 1) begin
                            m_lvl[c] = 1'b0; m_ones[c] = 0; m_zeros[c] = 0;
                        end
                    end else begin
                        m_zeros[c] = 0; m_el[c] = 0; m_rep[c] = 1'b0;
                    end
                end else begin
                    m_el[c]++;
                    if (!m_rep[c]) begin
                        if (m_el[c] >= RD && en[c]) begin
                            pulse = 1'b1; m_rep[c] = 1'b1; m_el[c] = 0;
                        end
                    end else if (!en[c]) begin
                        m_rep[c] = 1'b0; m_el[c] = 0;
                    end else if (m_el[c] >= RR) begin
                        pulse = 1'b1; m_el[c] = 0;
                    end
                end
            end
            e.p[c] = pulse;
            e.l[c] = m_lvl[c];
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic rst, input logic [N-1:0] pin, input logic [N-1:0] en);
        @(negedge clock);
        reset = rst; entrada = pin; repeat_en = en;
        @(posedge clock);
        model_edge(rst, pin, en);
    endtask

    // Monitor: every clock the DUT presents a result; compare against the queue.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("saida", {28'd0, saida}, {28'd0, mon_e.p});
            chk("nivel", {28'd0, nivel}, {28'd0, mon_e.l});
        end
    end

    initial begin
        logic [N-1:0] pin;
        logic [N-1:0] en;
        reset = 1'b1; entrada = 4'b1111; repeat_en = 4'b0000;
        cyc(1'b1, 4'b1111, 4'b0000);
        cyc(1'b1, 4'b1111, 4'b0000);

        // Idle panel: nothing happens.
        for (int i = 0; i < 20; i++) cyc(1'b0, 4'b1111, 4'b0000);

        // Reset while a button is held.
        for (int i = 0; i < 8; i++) cyc(1'b0, 4'b1110, 4'b0000);
        #1 chk("held_before_reset", {31'd0, nivel[0]}, 32'd1);
        cyc(1'b1, 4'b1110, 4'b0000);
        #1 chk("reset_saida", {28'd0, saida}, 32'd0);
        chk("reset_nivel", {28'd0, nivel}, 32'd0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 4'b1111, 4'b0000);

        // Channel 0: 12-clock press, then release, no repeat.
        for (int i = 0; i < 26; i++) begin
            cyc(1'b0, (i < 12) ? 4'b1110 : 4'b1111, 4'b0000);
            #1;
            chk("t2_saida0", {31'd0, saida[0]}, {31'd0, (i == 6)});
            chk("t2_nivel0", {31'd0, nivel[0]}, {31'd0, (i >= 6 && i < 18)});
        end

        // Channel 1: 3-clock glitch is rejected.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, (i < 3) ? 4'b1101 : 4'b1111, 4'b0000);
            #1 chk("t3_ch1", {30'd0, saida[1], nivel[1]}, 32'd0);
        end

        // Channel 2: held with auto-repeat.
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 4'b1011, 4'b0100);
            #1 chk("t4_saida2", {31'd0, saida[2]},
                   {31'd0, (i == 6 || i == 16 || i == 19 || i == 22 || i == 25 || i == 28)});
        end
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'b1111, 4'b0100);

        // Channel 2: repeat enable dropped for one clock mid-repeat.
        for (int i = 0; i < 40; i++) cyc(1'b0, 4'b1011, (i == 20) ? 4'b0000 : 4'b0100);
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'b1111, 4'b0000);

        // Channel 3: release with a short re-bounce keeps the level up.
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'b0111, 4'b0000);
        cyc(1'b0, 4'b1111, 4'b0000);
        cyc(1'b0, 4'b1111, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, (i < 2) ? 4'b0111 : 4'b1111, 4'b0000);
            #1 chk("t6_ch3", {30'd0, saida[3], nivel[3]}, 32'd1);
        end
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'b1111, 4'b0000);

        // Channels 0 and 1 pressed together pulse together.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 4'b1100, 4'b0000);
            #1 chk("t6_simul", {28'd0, saida}, (i == 6) ? 32'd3 : 32'd0);
        end
        for (int i = 0; i < 12; i++) cyc(1'b0, 4'b1111, 4'b0000);

        // Random phases: bouncy pins, then slow pins with long holds.
        pin = 4'b1111; en = 4'b0000;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 2500; i++) begin
                for (int c = 0; c < N; c++) begin
                    if ($urandom_range(0, (ph == 0) ? 7 : 39) == 0) pin[c] = ~pin[c];
                    if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
                end
                cyc(($urandom_range(0, 399) == 0), pin, en);
            end
        end

        @(negedge clock);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
